// File: rtl/alu_issue_ctrl.sv
// Issue/write-back sequencer wrapped around a combinational ALU.
// Owns the 32-entry register file and the architectural zero flag; one instruction in flight at a time.
module alu_issue_ctrl #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [31:0]              INSTR,
  input  logic                     INSTR_VALID,
  output logic                     INSTR_READY,
  output logic [DW-1:0]            OP1,
  output logic [DW-1:0]            OP2,
  output logic [2:0]               ALUSel,
  input  logic [DW-1:0]            ALU_RES,
  input  logic                     ALU_Z,
  output logic                     DONE,
  output logic                     ERR,
  output logic                     ZFLAG,
  input  logic [$clog2(NREGS)-1:0] DBG_ADDR,
  output logic [DW-1:0]            DBG_DATA
);

  localparam int AW = $clog2(NREGS);
  localparam logic [2:0] SEL_DIV = 3'b011;
  localparam logic [2:0] SEL_BAD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_RETIRE
  } state_t;

  state_t        state;
  logic [2:0]    sel_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] rs1_val;
  logic [DW-1:0] rs2_val;
  logic          reject;
  logic          unused_instr;

  assign unused_instr = ^INSTR[13:0];
  assign rs1_val      = regs[rs1_q];
  assign rs2_val      = regs[rs2_q];
  assign DBG_DATA     = regs[DBG_ADDR];
  assign reject       = (sel_q == SEL_BAD) || ((sel_q == SEL_DIV) && (rs2_val == '0));

  // Instruction fields are plain data: captured on the handshake, no reset needed.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && INSTR_VALID) begin
      sel_q <= INSTR[31:29];
      rd_q  <= INSTR[28:24];
      rs1_q <= INSTR[23:19];
      rs2_q <= INSTR[18:14];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      INSTR_READY <= 1'b1;
      OP1         <= '0;
      OP2         <= '0;
      ALUSel      <= 3'b000;
      ZFLAG       <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) begin
            INSTR_READY <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          // A rejected instruction retires without touching operands, select or flags.
          if (reject) begin
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            state <= S_RETIRE;
          end else begin
            OP1    <= rs1_val;
            OP2    <= rs2_val;
            ALUSel <= sel_q;
            state  <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          if (rd_q != '0) regs[rd_q] <= ALU_RES;
          ZFLAG <= ALU_Z;
          DONE  <= 1'b1;
          state <= S_RETIRE;
        end
        S_RETIRE: begin
          INSTR_READY <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          INSTR_READY <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a simple combinational ALU model.
module tb_alu_issue_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [2:0]  ALUSel;
  logic [31:0] ALU_RES;
  logic        ALU_Z;
  logic        DONE;
  logic        ERR;
  logic        ZFLAG;
  logic [4:0]  DBG_ADDR;
  logic [31:0] DBG_DATA;

  logic        force_en;
  logic [31:0] force_val;
  logic [31:0] alu_calc;

  int checks;
  int failures;

  alu_issue_ctrl #(.NREGS(32), .DW(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .OP1(OP1), .OP2(OP2), .ALUSel(ALUSel),
    .ALU_RES(ALU_RES), .ALU_Z(ALU_Z), .DONE(DONE), .ERR(ERR), .ZFLAG(ZFLAG),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU model: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 SLT (unsigned)
  always_comb begin
    alu_calc = '0;
    case (ALUSel)
      3'b000: alu_calc = OP1 + OP2;
      3'b001: alu_calc = OP1 - OP2;
      3'b010: alu_calc = OP1 * OP2;
      3'b011: alu_calc = (OP2 != 0) ? OP1 / OP2 : 32'hFFFF_FFFF;
      3'b100: alu_calc = OP1 & OP2;
      3'b101: alu_calc = OP1 | OP2;
      3'b110: alu_calc = {31'b0, OP1 < OP2};
      default: alu_calc = '0;
    endcase
    ALU_RES = force_en ? force_val : alu_calc;
  end
  assign ALU_Z = (ALU_RES == 32'h0);

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          fen;
    logic [31:0] fval;
    int          lat;
    bit          err;
    logic [31:0] rdval;
    bit          z;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [2:0] sel, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input bit fen, input logic [31:0] fval,
                              input bit err, input logic [31:0] rdval, input bit z);
    vec_t v;
    v.sel = sel; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.fen = fen; v.fval = fval;
    v.err = err; v.lat = err ? 2 : 4; v.rdval = rdval; v.z = z;
    return v;
  endfunction

  function automatic logic [31:0] enc(input logic [2:0] sel, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {sel, rd, rs1, rs2, 14'h2A5A};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    DBG_ADDR = a;
    #1;
    d = DBG_DATA;
  endtask

  task automatic issue(input logic [31:0] ins, output int lat, output logic err);
    int w;
    INSTR = ins;
    INSTR_VALID = 1'b1;
    w = 0;
    while (!INSTR_READY && w < 20) begin
      @(posedge CLK); #1;
      w++;
    end
    if (!INSTR_READY) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    lat = 1;
    while (!DONE && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    err = ERR;
    if (!DONE) lat = -1;
    @(posedge CLK); #1;
    chk("done_one_cycle", {31'b0, DONE}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        err;
    logic [31:0] d;
    logic [2:0]  prev_sel;
    int          rdy_cnt;
    int          done_cnt;
    int          bad_rdy;
    string       nm;

    checks = 0;
    failures = 0;
    RST_N = 1'b0;
    INSTR = '0;
    INSTR_VALID = 1'b0;
    DBG_ADDR = '0;
    force_en = 1'b0;
    force_val = '0;

    vecs[0]  = mk(3'b000, 5'd1,  5'd0, 5'd0, 1, 32'd7, 0, 32'd7,  0);
    vecs[1]  = mk(3'b000, 5'd2,  5'd0, 5'd0, 1, 32'd5, 0, 32'd5,  0);
    vecs[2]  = mk(3'b000, 5'd3,  5'd1, 5'd2, 0, 32'd0, 0, 32'd12, 0);
    vecs[3]  = mk(3'b001, 5'd4,  5'd1, 5'd1, 0, 32'd0, 0, 32'd0,  1);
    vecs[4]  = mk(3'b101, 5'd0,  5'd1, 5'd2, 0, 32'd0, 0, 32'd0,  0);
    vecs[5]  = mk(3'b000, 5'd5,  5'd1, 5'd2, 0, 32'd0, 0, 32'd12, 0);
    vecs[6]  = mk(3'b001, 5'd6,  5'd2, 5'd2, 0, 32'd0, 0, 32'd0,  1);
    vecs[7]  = mk(3'b011, 5'd5,  5'd1, 5'd0, 0, 32'd0, 1, 32'd12, 1);
    vecs[8]  = mk(3'b111, 5'd7,  5'd1, 5'd2, 0, 32'd0, 1, 32'd0,  1);
    vecs[9]  = mk(3'b010, 5'd7,  5'd1, 5'd2, 0, 32'd0, 0, 32'd35, 0);
    vecs[10] = mk(3'b110, 5'd8,  5'd2, 5'd1, 0, 32'd0, 0, 32'd1,  0);
    vecs[11] = mk(3'b011, 5'd9,  5'd1, 5'd2, 0, 32'd0, 0, 32'd1,  0);
    vecs[12] = mk(3'b100, 5'd10, 5'd1, 5'd2, 0, 32'd0, 0, 32'd5,  0);
    vecs[13] = mk(3'b000, 5'd1,  5'd1, 5'd1, 0, 32'd0, 0, 32'd14, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'b0, INSTR_READY}, 32'h1);
    chk("rst_done",  {31'b0, DONE}, 32'h0);
    chk("rst_err",   {31'b0, ERR}, 32'h0);
    chk("rst_zflag", {31'b0, ZFLAG}, 32'h0);
    chk("rst_op1", OP1, 32'h0);
    chk("rst_op2", OP2, 32'h0);
    chk("rst_alusel", {29'b0, ALUSel}, 32'h0);
    RST_N = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_reg(5'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 32'h0);
    end
    @(posedge CLK); #1;

    prev_sel = 3'b000;
    for (int i = 0; i < 14; i++) begin
      force_en  = vecs[i].fen;
      force_val = vecs[i].fval;
      issue(enc(vecs[i].sel, vecs[i].rd, vecs[i].rs1, vecs[i].rs2), lat, err);
      force_en  = 1'b0;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_zflag", i), {31'b0, ZFLAG}, {31'b0, vecs[i].z});
      if (!vecs[i].err) prev_sel = vecs[i].sel;
      chk($sformatf("v%0d_alusel", i), {29'b0, ALUSel}, {29'b0, prev_sel});
      rd_reg(vecs[i].rd, d);
      chk($sformatf("v%0d_rd", i), d, vecs[i].rdval);
    end
    chk("reject_op1_held", OP1, 32'd7);
    rd_reg(5'd0, d);
    chk("r0_zero", d, 32'h0);

    // Valid held high: one acceptance per five cycles, r11 accumulates r1 (14) each time.
    @(posedge CLK); #1;
    INSTR = enc(3'b000, 5'd11, 5'd11, 5'd1);
    INSTR_VALID = 1'b1;
    rdy_cnt = 0;
    done_cnt = 0;
    bad_rdy = 0;
    for (int c = 0; c < 20; c++) begin
      if (INSTR_READY) begin
        rdy_cnt++;
        if (c % 5 != 0) bad_rdy++;
      end
      if (DONE) done_cnt++;
      @(posedge CLK); #1;
    end
    INSTR_VALID = 1'b0;
    repeat (6) begin
      if (DONE) done_cnt++;
      @(posedge CLK); #1;
    end
    chk("stream_ready_cnt", 32'(rdy_cnt), 32'd4);
    chk("stream_ready_phase", 32'(bad_rdy), 32'd0);
    chk("stream_done_cnt", 32'(done_cnt), 32'd4);
    rd_reg(5'd11, d);
    chk("stream_r11", d, 32'd56);

    // Reset during EXEC of ADD r6 = r1 + r2.
    @(posedge CLK); #1;
    INSTR = enc(3'b000, 5'd6, 5'd1, 5'd2);
    INSTR_VALID = 1'b1;
    chk("pre_abort_ready", {31'b0, INSTR_READY}, 32'h1);
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("abort_ready", {31'b0, INSTR_READY}, 32'h1);
    done_cnt = 0;
    repeat (2) begin
      @(posedge CLK); #1;
      if (DONE) done_cnt++;
    end
    RST_N = 1'b1;
    repeat (6) begin
      @(posedge CLK); #1;
      if (DONE) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_ready_idle", {31'b0, INSTR_READY}, 32'h1);
    rd_reg(5'd6, d);
    chk("abort_r6", d, 32'h0);
    rd_reg(5'd1, d);
    chk("abort_r1_cleared", d, 32'h0);
    chk("abort_alusel", {29'b0, ALUSel}, 32'h0);

    force_en = 1'b1;
    force_val = 32'd9;
    issue(enc(3'b000, 5'd2, 5'd0, 5'd0), lat, err);
    force_en = 1'b0;
    chk("post_latency", 32'(lat), 32'd4);
    chk("post_err", {31'b0, err}, 32'h0);
    rd_reg(5'd2, d);
    chk("post_r2", d, 32'd9);

    nm = "";
    $display("TB_RESULT checks=%0d failures=%0d%s", checks, failures, nm);
    $finish;
  end

endmodule
